// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the high time and period of one PWM input in units of the shared tick.
// Latency: 2 clk synchronizer, then results register on the tick that sees the closing rising edge.
// Backpressure: none; meas_valid is a 1-clk pulse and the consumer must take the outputs when it appears.

module pwm_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [7:0]       duty8,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(255);

    // synchronizer and sample-edge state
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       warm_q, warm_d;
    logic             prev_q, prev_d;

    // measurement state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] hc_q, hc_d;

    // registered outputs
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [7:0]       duty8_q, duty8_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_hi_q, stuck_hi_d;
    logic             stuck_lo_q, stuck_lo_d;

    // combinational helpers
    logic             samp_en;
    logic             s;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] pc_inc;
    logic [CNT_W-1:0] hc_inc;
    logic [7:0]       duty_meas;
    logic             tmo_hit;

    // Input path: 2-flop synchronizer and tick-qualified edge detection.
    // warm_q holds sampling off until the synchronizer carries a real sample, so an input
    // that is already high at reset release is never seen as a 0->1 edge.
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        warm_d  = {warm_q[0], 1'b1};
        samp_en = tick & warm_q[1];
        s       = sync2_q;
        rise    = samp_en & s & ~prev_q;
        fall    = samp_en & ~s & prev_q;
        prev_d  = samp_en ? s : prev_q;
    end

    // Saturating counter increments, duty code of the running high count, timeout detect.
    always_comb begin
        pc_inc    = (pc_q == CNT_MAX) ? pc_q : pc_q + CNT_ONE;
        hc_inc    = (hc_q == CNT_MAX) ? hc_q : hc_q + CNT_ONE;
        duty_meas = (hc_q > DUTY_MAX) ? 8'hFF : hc_q[7:0];
        tmo_hit   = (pc_inc >= TMO);
    end

    // Measurement FSM: next state, counters and published results; only tick cycles advance it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hc_d         = hc_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        duty8_d      = duty8_q;
        stuck_hi_d   = stuck_hi_q;
        stuck_lo_d   = stuck_lo_q;
        meas_valid_d = 1'b0;

        if (samp_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        // first edge only opens a period; nothing to publish yet
                        pc_d       = CNT_ONE;
                        hc_d       = CNT_ONE;
                        stuck_hi_d = 1'b0;
                        stuck_lo_d = 1'b0;
                        state_d    = ST_HIGH;
                    end else if (pc_q < TMO) begin
                        // pc parks at TMO once reached, so the stuck report happens once
                        pc_d = pc_inc;
                        if (tmo_hit) begin
                            high_cnt_d   = '0;
                            period_cnt_d = '0;
                            stuck_hi_d   = s;
                            stuck_lo_d   = ~s;
                            duty8_d      = s ? 8'hFF : 8'h00;
                            meas_valid_d = 1'b1;
                        end
                    end
                end

                ST_HIGH: begin
                    pc_d = pc_inc;
                    if (s) begin
                        hc_d = hc_inc;
                    end
                    if (fall) begin
                        state_d = ST_LOW;
                    end
                    if (tmo_hit) begin
                        high_cnt_d   = '0;
                        period_cnt_d = '0;
                        stuck_hi_d   = s;
                        stuck_lo_d   = ~s;
                        duty8_d      = s ? 8'hFF : 8'h00;
                        meas_valid_d = 1'b1;
                        pc_d         = TMO;
                        state_d      = ST_IDLE;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        // the closing edge wins over a coincident timeout and belongs to the next period
                        high_cnt_d   = hc_q;
                        period_cnt_d = pc_q;
                        duty8_d      = duty_meas;
                        meas_valid_d = 1'b1;
                        pc_d         = CNT_ONE;
                        hc_d         = CNT_ONE;
                        state_d      = ST_HIGH;
                    end else begin
                        pc_d = pc_inc;
                        if (tmo_hit) begin
                            high_cnt_d   = '0;
                            period_cnt_d = '0;
                            stuck_hi_d   = s;
                            stuck_lo_d   = ~s;
                            duty8_d      = s ? 8'hFF : 8'h00;
                            meas_valid_d = 1'b1;
                            pc_d         = TMO;
                            state_d      = ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            warm_q       <= 2'b00;
            prev_q       <= 1'b1;
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            hc_q         <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            duty8_q      <= 8'h00;
            meas_valid_q <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            warm_q       <= warm_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            pc_q         <= pc_d;
            hc_q         <= hc_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            duty8_q      <= duty8_d;
            meas_valid_q <= meas_valid_d;
            stuck_hi_q   <= stuck_hi_d;
            stuck_lo_q   <= stuck_lo_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign duty8      = duty8_q;
    assign meas_valid = meas_valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;

    // a publish never repeats on the next clk, and the two stuck flags are exclusive
    a_valid_pulse: assert property (@(posedge clk) disable iff (rst) meas_valid_q |=> !meas_valid_q);
    a_stuck_excl:  assert property (@(posedge clk) disable iff (rst) !(stuck_hi_q && stuck_lo_q));

endmodule
